// File: rtl/sd_spi_pkg.sv
// Shared constants, framer state encoding and the CRC7 helper for the SD SPI card model.
package sd_spi_pkg;

   localparam logic [6:0] CRC7_POLY  = 7'h09;
   localparam logic [1:0] START_MASK = 2'b11;
   localparam logic [1:0] START_VAL  = 2'b01;

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_ARG  = 2'd1,
      ST_CRC  = 2'd2
   } framer_state_e;

   // x^7 + x^3 + 1, MSB-first, one byte at a time
   function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
      logic [6:0] c;
      logic       fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[6] ^ data[i];
         c  = {c[5:0], 1'b0};
         if (fb) begin
            c = c ^ CRC7_POLY;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/sd_cmd_framer.sv
// Frames received bytes into 6-byte SD commands: index, 32-bit argument, CRC7 field and check.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_HUNT | waiting for a byte with start/transmission bits 2'b01
//  ST_ARG  | collecting the four argument bytes, running CRC7
//  ST_CRC  | next byte is CRC7 + stop bit; strobe cmd_valid and return
module sd_cmd_framer
   import sd_spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        abort,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic [6:0]  cmd_crc,
   output logic        cmd_crc_ok,
   output logic        cmd_valid
);

   framer_state_e state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [6:0]    crc_q, crc_d;
   logic [5:0]    index_q, index_d;
   logic [31:0]   arg_q, arg_d;
   logic [6:0]    crc_field_q, crc_field_d;
   logic          crc_ok_q, crc_ok_d;
   logic          valid_q, valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HUNT;
         cnt_q       <= 2'd0;
         crc_q       <= 7'd0;
         index_q     <= 6'd0;
         arg_q       <= 32'd0;
         crc_field_q <= 7'd0;
         crc_ok_q    <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         crc_q       <= crc_d;
         index_q     <= index_d;
         arg_q       <= arg_d;
         crc_field_q <= crc_field_d;
         crc_ok_q    <= crc_ok_d;
         valid_q     <= valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      crc_d       = crc_q;
      index_d     = index_q;
      arg_d       = arg_q;
      crc_field_d = crc_field_q;
      crc_ok_d    = crc_ok_q;
      valid_d     = 1'b0;
      if (abort) begin
         state_d = ST_HUNT;
      end else if (byte_valid) begin
         case (state_q)
            ST_HUNT: begin
               if ((byte_data[7:6] & START_MASK) == START_VAL) begin
                  index_d = byte_data[5:0];
                  crc_d   = crc7_byte(7'd0, byte_data);
                  cnt_d   = 2'd0;
                  state_d = ST_ARG;
               end
            end
            ST_ARG: begin
               arg_d = {arg_q[23:0], byte_data};
               crc_d = crc7_byte(crc_q, byte_data);
               if (cnt_q == 2'd3) begin
                  state_d = ST_CRC;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            ST_CRC: begin
               crc_field_d = byte_data[7:1];
               crc_ok_d    = (crc_q == byte_data[7:1]) && byte_data[0];
               valid_d     = 1'b1;
               state_d     = ST_HUNT;
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   assign cmd_index  = index_q;
   assign cmd_arg    = arg_q;
   assign cmd_crc    = crc_field_q;
   assign cmd_crc_ok = crc_ok_q;
   assign cmd_valid  = valid_q;

endmodule

// File: rtl/sd_spi_responder.sv
// SPI mode-0 SD card target: synchronizes the host pins, shifts bytes both ways and
// hands received bytes to the command framer.
module sd_spi_responder
   import sd_spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 3,
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
   input  logic        C100M,
   input  logic        RESET_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_OE,
   input  logic [7:0]  TX_DATA,
   input  logic        TX_VALID,
   output logic        TX_READY,
   output logic [7:0]  RX_DATA,
   output logic        RX_VALID,
   output logic [5:0]  CMD_INDEX,
   output logic [31:0] CMD_ARG,
   output logic [6:0]  CMD_CRC,
   output logic        CMD_CRC_OK,
   output logic        CMD_VALID,
   output logic        BUSY
);

   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic       sel_q, sel_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       miso_q, miso_d;
   logic       ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s, tx_load;

   always_ff @(posedge C100M or negedge RESET_n) begin
      if (!RESET_n) begin
         ss_sync_q   <= '1;
         sclk_sync_q <= '0;
         mosi_sync_q <= '1;
         sel_q       <= 1'b0;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 8'd0;
         tx_shift_q  <= IDLE_BYTE;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
         rx_data_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         miso_q      <= 1'b1;
      end else begin
         ss_sync_q   <= ss_sync_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sel_q       <= sel_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         miso_q      <= miso_d;
      end
   end

   // Edges come from the two oldest stages; MOSI is taken from its oldest stage, which
   // still lies well inside the half-period the host holds it stable.
   always_comb begin
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_fall     = ss_sync_q[SYNC_STAGES-1] & ~ss_sync_q[SYNC_STAGES-2];
      ss_rise     = ~ss_sync_q[SYNC_STAGES-1] & ss_sync_q[SYNC_STAGES-2];
      sclk_rise   = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES-2];
      sclk_fall   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES-2];
      mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   end

   always_comb begin
      sel_d       = sel_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_load     = 1'b0;

      if (ss_fall) begin
         sel_d      = 1'b1;
         bit_cnt_d  = 3'd0;
         rx_shift_d = 8'd0;
         tx_load    = 1'b1;
      end else if (ss_rise) begin
         sel_d      = 1'b0;
         bit_cnt_d  = 3'd0;
         rx_shift_d = 8'd0;
      end else if (sel_q) begin
         if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               rx_data_d  = rx_shift_d;
               rx_valid_d = 1'b1;
            end
         end else if (sclk_fall) begin
            if (bit_cnt_q == 3'd0) begin
               tx_load = 1'b1;
            end else begin
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
         end
      end

      // A load from an empty holding register sends IDLE_BYTE even if a byte is
      // accepted in the same cycle; that byte waits for the next boundary.
      if (tx_load) begin
         if (hold_full_q) begin
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
         end else begin
            tx_shift_d = IDLE_BYTE;
         end
      end
      if (TX_VALID && !hold_full_q) begin
         hold_d      = TX_DATA;
         hold_full_d = 1'b1;
      end

      miso_d = sel_d ? tx_shift_d[7] : 1'b1;
   end

   sd_cmd_framer u_framer (
      .clk        (C100M),
      .rst_n      (RESET_n),
      .byte_valid (rx_valid_q),
      .byte_data  (rx_data_q),
      .abort      (ss_rise),
      .cmd_index  (CMD_INDEX),
      .cmd_arg    (CMD_ARG),
      .cmd_crc    (CMD_CRC),
      .cmd_crc_ok (CMD_CRC_OK),
      .cmd_valid  (CMD_VALID)
   );

   assign MISO     = miso_q;
   assign MISO_OE  = sel_q;
   assign TX_READY = ~hold_full_q;
   assign RX_DATA  = rx_data_q;
   assign RX_VALID = rx_valid_q;
   assign BUSY     = sel_q | (bit_cnt_q != 3'd0);

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: command frame table plus hand sequences for
// TX handshake, partial frames, mid-byte deselect, async reset and an SCLK rate sweep.
module tb_sd_spi_responder;

   logic        C100M    = 1'b0;
   logic        RESET_n  = 1'b0;
   logic        SS_n     = 1'b1;
   logic        SCLK     = 1'b0;
   logic        MOSI     = 1'b1;
   logic [7:0]  TX_DATA  = 8'd0;
   logic        TX_VALID = 1'b0;
   logic        MISO, MISO_OE, TX_READY, RX_VALID, CMD_CRC_OK, CMD_VALID, BUSY;
   logic [7:0]  RX_DATA;
   logic [5:0]  CMD_INDEX;
   logic [31:0] CMD_ARG;
   logic [6:0]  CMD_CRC;

   int errors = 0;
   int checks = 0;
   int rx_cnt = 0;
   int cmd_cnt = 0;
   logic [7:0]  rx_last = 8'd0;
   logic [5:0]  cap_idx = 6'd0;
   logic [31:0] cap_arg = 32'd0;
   logic [6:0]  cap_crc = 7'd0;
   logic        cap_ok = 1'b0;

   always #5 C100M = ~C100M;

   sd_spi_responder #(.SYNC_STAGES(3), .IDLE_BYTE(8'hFF)) dut (
      .C100M(C100M), .RESET_n(RESET_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .MISO_OE(MISO_OE), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
      .TX_READY(TX_READY), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .CMD_INDEX(CMD_INDEX), .CMD_ARG(CMD_ARG), .CMD_CRC(CMD_CRC),
      .CMD_CRC_OK(CMD_CRC_OK), .CMD_VALID(CMD_VALID), .BUSY(BUSY)
   );

   always @(negedge C100M) begin
      if (RX_VALID) begin
         rx_cnt  <= rx_cnt + 1;
         rx_last <= RX_DATA;
      end
      if (CMD_VALID) begin
         cmd_cnt <= cmd_cnt + 1;
         cap_idx <= CMD_INDEX;
         cap_arg <= CMD_ARG;
         cap_crc <= CMD_CRC;
         cap_ok  <= CMD_CRC_OK;
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge C100M);
   endtask

   // Mode 0: MOSI set half a period before the rising edge, MISO sampled at the rise.
   task automatic xfer(input logic [7:0] tx, input int nbits, input int half,
                       output logic [7:0] rx);
      rx = 8'd0;
      for (int i = 7; i > 7 - nbits; i--) begin
         MOSI = tx[i];
         wait_clk(half);
         SCLK = 1'b1;
         rx[i] = MISO;
         wait_clk(half);
         SCLK = 1'b0;
      end
   endtask

   task automatic sel();
      SS_n = 1'b0;
      wait_clk(10);
   endtask

   task automatic desel();
      wait_clk(10);
      SS_n = 1'b1;
      wait_clk(10);
   endtask

   task automatic push_tx(input logic [7:0] d);
      int n = 0;
      while (!TX_READY && n < 300) begin
         wait_clk(1);
         n++;
      end
      chk("push_tx_ready", {31'd0, TX_READY}, 32'd1);
      if (TX_READY) begin
         TX_DATA  = d;
         TX_VALID = 1'b1;
         wait_clk(1);
         TX_VALID = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [47:0] f, input int half);
      logic [7:0] r;
      for (int k = 0; k < 6; k++) begin
         xfer(f[47-8*k -: 8], 8, half, r);
      end
   endtask

   typedef struct packed {
      logic [47:0] frame;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [6:0]  crc;
      logic        ok;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int rc0, cc0;
      logic [7:0] r0, r1;
      int halves [7];
      logic [7:0] txb [4];
      logic [7:0] mob [4];

      vecs[0] = '{48'h40_0000_0000_95, 6'd0,  32'h0000_0000, 7'h4A, 1'b1};
      vecs[1] = '{48'h48_0000_01AA_87, 6'd8,  32'h0000_01AA, 7'h43, 1'b1};
      vecs[2] = '{48'h48_0000_01AA_86, 6'd8,  32'h0000_01AA, 7'h43, 1'b0};
      vecs[3] = '{48'h77_0000_0000_65, 6'd55, 32'h0000_0000, 7'h32, 1'b1};
      vecs[4] = '{48'h69_4000_0000_77, 6'd41, 32'h4000_0000, 7'h3B, 1'b1};
      vecs[5] = '{48'h40_0000_0000_97, 6'd0,  32'h0000_0000, 7'h4B, 1'b0};
      halves  = '{5, 7, 11, 17, 26, 38, 50};

      // Reset state
      wait_clk(4);
      chk("rst_miso",     {31'd0, MISO},      32'd1);
      chk("rst_miso_oe",  {31'd0, MISO_OE},   32'd0);
      chk("rst_tx_ready", {31'd0, TX_READY},  32'd1);
      chk("rst_rx_valid", {31'd0, RX_VALID},  32'd0);
      chk("rst_cmd_valid",{31'd0, CMD_VALID}, 32'd0);
      chk("rst_rx_data",  {24'd0, RX_DATA},   32'd0);
      chk("rst_cmd_arg",  CMD_ARG,            32'd0);
      chk("rst_busy",     {31'd0, BUSY},      32'd0);
      RESET_n = 1'b1;
      wait_clk(10);

      // Command frame table
      for (int i = 0; i < 6; i++) begin
         rc0 = rx_cnt;
         cc0 = cmd_cnt;
         sel();
         send_frame(vecs[i].frame, 5 + 3 * i);
         desel();
         chk("vec_rx_count",  rx_cnt,  rc0 + 6);
         chk("vec_cmd_count", cmd_cnt, cc0 + 1);
         chk("vec_rx_last",   {24'd0, rx_last}, {24'd0, vecs[i].frame[7:0]});
         chk("vec_index",     {26'd0, cap_idx}, {26'd0, vecs[i].idx});
         chk("vec_arg",       cap_arg,          vecs[i].arg);
         chk("vec_crc",       {25'd0, cap_crc}, {25'd0, vecs[i].crc});
         chk("vec_crc_ok",    {31'd0, cap_ok},  {31'd0, vecs[i].ok});
      end

      // TX holding: byte queued before select goes out first, then idle fill
      cc0 = cmd_cnt;
      push_tx(8'h01);
      wait_clk(2);
      chk("tx_ready_full", {31'd0, TX_READY}, 32'd0);
      chk("oe_desel",      {31'd0, MISO_OE},  32'd0);
      sel();
      chk("oe_sel",        {31'd0, MISO_OE},  32'd1);
      chk("busy_sel",      {31'd0, BUSY},     32'd1);
      chk("tx_ready_load", {31'd0, TX_READY}, 32'd1);
      xfer(8'h40, 8, 6, r0);
      xfer(8'h00, 8, 6, r1);
      chk("tx_byte0", {24'd0, r0}, 32'h01);
      chk("tx_byte1", {24'd0, r1}, 32'hFF);
      desel();
      chk("miso_desel", {31'd0, MISO},    32'd1);
      chk("oe_off",     {31'd0, MISO_OE}, 32'd0);
      chk("busy_off",   {31'd0, BUSY},    32'd0);
      chk("partial_no_cmd", cmd_cnt, cc0);

      // Partial CMD17 then a clean CMD0
      cc0 = cmd_cnt;
      sel();
      xfer(8'h51, 8, 6, r0);
      xfer(8'h00, 8, 6, r0);
      xfer(8'h00, 8, 6, r0);
      desel();
      chk("cmd17_aborted", cmd_cnt, cc0);
      sel();
      send_frame(48'h40_0000_0000_95, 6);
      desel();
      chk("cmd0_after_abort_cnt", cmd_cnt, cc0 + 1);
      chk("cmd0_after_abort_idx", {26'd0, cap_idx}, 32'd0);
      chk("cmd0_after_abort_ok",  {31'd0, cap_ok},  32'd1);

      // Fill bytes ahead of the frame are ignored by the hunter
      cc0 = cmd_cnt;
      sel();
      xfer(8'hFF, 8, 6, r0);
      xfer(8'hFF, 8, 6, r0);
      send_frame(48'h48_0000_01AA_87, 6);
      desel();
      chk("hunt_cnt", cmd_cnt, cc0 + 1);
      chk("hunt_idx", {26'd0, cap_idx}, 32'd8);
      chk("hunt_arg", cap_arg, 32'h0000_01AA);

      // Deselect mid-byte drops the partial byte and restarts the bit count
      rc0 = rx_cnt;
      sel();
      xfer(8'hA5, 4, 6, r0);
      desel();
      chk("midbyte_no_rx", rx_cnt, rc0);
      sel();
      xfer(8'h3C, 8, 6, r0);
      desel();
      chk("midbyte_next_cnt",  rx_cnt, rc0 + 1);
      chk("midbyte_next_data", {24'd0, rx_last}, 32'h3C);

      // SCLK rate sweep with random data both ways
      foreach (halves[h]) begin
         for (int k = 0; k < 4; k++) begin
            txb[k] = 8'($urandom_range(0, 255));
            mob[k] = 8'($urandom_range(0, 255));
         end
         push_tx(txb[0]);
         sel();
         for (int k = 0; k < 4; k++) begin
            if (k + 1 < 4) push_tx(txb[k+1]);
            xfer(mob[k], 8, halves[h], r0);
            wait_clk(4);
            chk("sweep_miso", {24'd0, r0},      {24'd0, txb[k]});
            chk("sweep_mosi", {24'd0, rx_last}, {24'd0, mob[k]});
         end
         desel();
      end

      // Async reset in the middle of a frame
      sel();
      xfer(8'h51, 8, 6, r0);
      xfer(8'h00, 8, 6, r0);
      wait_clk(6);
      chk("pre_reset_idx", {26'd0, CMD_INDEX}, 32'h11);
      #2 RESET_n = 1'b0;
      #2;
      chk("reset_idx",      {26'd0, CMD_INDEX}, 32'd0);
      chk("reset_oe",       {31'd0, MISO_OE},   32'd0);
      chk("reset_miso",     {31'd0, MISO},      32'd1);
      chk("reset_busy",     {31'd0, BUSY},      32'd0);
      chk("reset_tx_ready", {31'd0, TX_READY},  32'd1);
      SS_n = 1'b1;
      SCLK = 1'b0;
      wait_clk(3);
      RESET_n = 1'b1;
      wait_clk(10);
      cc0 = cmd_cnt;
      sel();
      send_frame(48'h40_0000_0000_95, 5);
      desel();
      chk("post_reset_cnt", cmd_cnt, cc0 + 1);
      chk("post_reset_ok",  {31'd0, cap_ok}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
